data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for CPU data-memory load/store requests, with configurable wait states.
//  Serves one request at a time through a req/ack handshake and backs a word-addressed
//  storage array. Sits between the CPU datapath and data storage, replacing a zero-latency memory.
// PARAMETERS
//  DEPTH     128  number of 32-bit words stored; must be a power of 2, >= 2
//  WAIT_CYC  2    wait states between request acceptance and ack; range 0..15
// PORTS
//  clk_i    in   1   clock, rising edge
//  rst_i    in   1   reset, asynchronous, active-low
//  req_i    in   1   request strobe; sampled only when busy_o == 0
//  we_i     in   1   1 = store, 0 = load; sampled with req_i
//  addr_i   in   32  byte address; sampled with req_i
//  wdata_i  in   32  store data; sampled with req_i
//  rdata_o  out  32  load data; valid while ack_o == 1, then held
//  ack_o    out  1   one-cycle completion pulse
//  busy_o   out  1   1 while a request is in flight (WAIT or RESP state)
//  err_o    out  1   misaligned-access flag, qualified by ack_o (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_i = 0, asynchronous): state = IDLE; ack_o, busy_o, err_o = 0; rdata_o = 32'h0; wait counter = 0.
//   The storage array is not cleared.
//  Word index = addr_i[$clog2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
//  FSM states:
//   IDLE: busy_o = 0. If req_i = 1 on an edge, latch we/addr/wdata.
//    Go to WAIT with counter = WAIT_CYC-1 when WAIT_CYC > 0; otherwise go to RESP.
//   WAIT: busy_o = 1. Decrement the counter each edge. Go to RESP on the edge where the counter == 0.
//   RESP: busy_o = 1, ack_o = 1 for exactly one cycle. Go to IDLE on the next edge.
//  Timing: request accepted at edge T, so ack_o is high in the cycle after edge T+WAIT_CYC.
//   A new request can be accepted at the edge that ends RESP+1, i.e. one IDLE cycle minimum between requests.
//  Store: the array word is written on the edge that enters RESP. rdata_o is unchanged on stores.
//  Load: rdata_o is loaded from the array on the edge that enters RESP, and holds until the next load completes.
//  Read-after-write to the same address in back-to-back transactions returns the new data.
//  req_i asserted while busy_o = 1 is ignored; no queueing and no error.
//  Reset asserted mid-WAIT/RESP: the transaction is aborted and no ack is issued.
//   If the write edge has not occurred, the array is unmodified.
// CONFIGURATION
//  MEM_ALIGN_CHK_EN defined:
//   - A request with addr_i[1:0] != 0 follows the same FSM and latency.
//   - At RESP: err_o = 1, the store is suppressed, and rdata_o = 32'h0.
//   - err_o = 0 on aligned accesses and whenever ack_o = 0.
//  MEM_ALIGN_CHK_EN undefined: addr_i[1:0] is ignored (word-truncated access) and err_o is tied to 0.
// STRUCTURE
//  Package mem_resp_pkg:
//   - state enum {IDLE, WAIT, RESP} (2 bits)
//   - WORD_W = 32
//   - helper function for the word index width
//  One sub-module: dmem_array (DEPTH x 32 synchronous-write, registered-read storage with
//   we/idx/wdata/rdata ports, no reset). The FSM, latches and counter stay in data_mem_responder.
// TESTING (DEPTH = 128, WAIT_CYC = 2 unless noted)
//  1. Store addr 0x10, data 0xDEADBEEF, then load 0x10 -> ack_o exactly 3 cycles after each acceptance edge;
//     rdata_o = 0xDEADBEEF, busy_o high for 3 cycles.
//  2. WAIT_CYC = 0: load 0x10 -> ack_o in the cycle immediately after acceptance. WAIT_CYC = 15 -> ack 16 cycles after acceptance.
//  3. Hold req_i high continuously with alternating store 0x20 = 0x1 and load 0x20 -> one transaction per 4 cycles;
//     requests during busy are ignored; the load returns 0x1.
//  4. Store 0x0 = 0xA5A5A5A5, then load 0x200 (wraps to index 0) -> rdata_o = 0xA5A5A5A5.
//  5. Start a store 0x30 = 0x55, pulse rst_i low during WAIT -> no ack_o, all outputs 0 immediately,
//     and a subsequent load of 0x30 returns its prior value.
//  6. With MEM_ALIGN_CHK_EN: store 0x31 = 0xFF -> ack_o with err_o = 1, and a load of 0x30 returns the old value.
//     Without the macro: the same store writes index 12 and err_o = 0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package mem_resp_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W storage: synchronous write, registered read-before-write, no reset.
module dmem_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [idx_width(DEPTH)-1:0]  idx_i,
  input  logic [WORD_W-1:0]            wdata_i,
  output logic [WORD_W-1:0]            rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_o <= mem_q[idx_i];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Req/ack data-memory responder with WAIT_CYC wait states in front of a word array.
// Define MEM_ALIGN_CHK_EN to flag misaligned accesses on err_o and suppress their effects.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int IW = idx_width(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic               mis_q;
  logic [IW-1:0]      idx_q;
  logic [WORD_W-1:0]  wdata_q;
  logic [WORD_W-1:0]  rdata_q;
  logic               ack_q;
  logic               busy_q;
  logic               err_q;

  logic [IW-1:0]      idx_in;
  logic               mis_in;
  logic               enter_resp;
  logic               arr_we;
  logic [IW-1:0]      arr_idx;
  logic [WORD_W-1:0]  arr_wdata;
  logic [WORD_W-1:0]  arr_rdata;
  logic               show_new;
  logic [WORD_W-1:0]  resp_val;
  logic               unused_addr;

  assign idx_in      = addr_i[IW+1:2];
  assign unused_addr = ^{addr_i[31:IW+2], addr_i[1:0]};

`ifdef MEM_ALIGN_CHK_EN
  assign mis_in = |addr_i[1:0];
`else
  assign mis_in = 1'b0;
`endif

  // With zero wait states the RESP-entry edge is the acceptance edge, so the
  // array is fed from the live inputs while IDLE and from the latches otherwise.
  assign enter_resp = ((state_q == IDLE) && req_i && (WAIT_CYC == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));
  assign arr_idx    = (state_q == IDLE) ? idx_in : idx_q;
  assign arr_wdata  = (state_q == IDLE) ? wdata_i : wdata_q;
  assign arr_we     = enter_resp &&
                      ((state_q == IDLE) ? (we_i && !mis_in) : (we_q && !mis_q));

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (arr_we),
    .idx_i  (arr_idx),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );

  // During RESP the registered array output already holds the addressed word;
  // it is shown directly and captured into rdata_q when RESP ends.
  assign resp_val = mis_q ? '0 : arr_rdata;
  assign show_new = (state_q == RESP) && (!we_q || mis_q);
  assign rdata_o  = show_new ? resp_val : rdata_q;
  assign ack_o    = ack_q;
  assign busy_o   = busy_q;
  assign err_o    = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            mis_q   <= mis_in;
            idx_q   <= idx_in;
            wdata_q <= wdata_i;
            busy_q  <= 1'b1;
            if (WAIT_CYC > 0) begin
              state_q <= WAIT;
              cnt_q   <= WAIT_INIT;
            end else begin
              state_q <= RESP;
              ack_q   <= 1'b1;
              err_q   <= mis_in;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            err_q   <= mis_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!we_q || mis_q) begin
            rdata_q <= resp_val;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected acks, a negedge monitor checks them.
// Misaligned-access expectations follow MEM_ALIGN_CHK_EN.
module tb_data_mem_responder;

  localparam int WAIT_CYC = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          ackCycle;
  } expT;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ack, busy, err;

  logic        req2, we2;
  logic [31:0] addr2, wdata2;
  logic [31:0] rdata0, rdata15;
  logic        ack0, busy0, err0, ack15, busy15, err15;

  int  cyc = 0;
  int  compared = 0;
  int  mismatched = 0;
  expT expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(128), .WAIT_CYC(WAIT_CYC)) u_dut (
    .clk_i(clk), .rst_i(rstN), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .ack_o(ack), .busy_o(busy), .err_o(err)
  );

  data_mem_responder #(.DEPTH(128), .WAIT_CYC(0)) u_w0 (
    .clk_i(clk), .rst_i(rstN), .req_i(req2), .we_i(we2), .addr_i(addr2), .wdata_i(wdata2),
    .rdata_o(rdata0), .ack_o(ack0), .busy_o(busy0), .err_o(err0)
  );

  data_mem_responder #(.DEPTH(128), .WAIT_CYC(15)) u_w15 (
    .clk_i(clk), .rst_i(rstN), .req_i(req2), .we_i(we2), .addr_i(addr2), .wdata_i(wdata2),
    .rdata_o(rdata15), .ack_o(ack15), .busy_o(busy15), .err_o(err15)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Issue one request at the next edge and wait for the responder to go idle.
  task automatic applyStimulus(input logic weV, input logic [31:0] addrV,
                               input logic [31:0] wdataV, input logic [31:0] expRd,
                               input logic expErr);
    expT e;
    int  n;
    req = 1'b1; we = weV; addr = addrV; wdata = wdataV;
    e.rdata = expRd; e.err = expErr; e.ackCycle = cyc + 1 + WAIT_CYC;
    expQ.push_back(e);
    @(posedge clk); #2;
    req = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    checkOutput("busyCycles", 32'(n), 32'(WAIT_CYC + 1));
  endtask

  task automatic latencyRun(input logic weV, input logic [31:0] addrV,
                            input logic [31:0] wdataV, input logic [31:0] expRd,
                            input string tag);
    int startC, a0, a15;
    logic [31:0] r0, r15;
    a0 = -1; a15 = -1; r0 = '0; r15 = '0;
    req2 = 1'b1; we2 = weV; addr2 = addrV; wdata2 = wdataV;
    startC = cyc + 1;
    @(posedge clk); #2;
    req2 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack0 && a0 < 0) begin a0 = cyc; r0 = rdata0; end
      if (ack15 && a15 < 0) begin a15 = cyc; r15 = rdata15; end
      if (a0 >= 0 && a15 >= 0 && !busy0 && !busy15) break;
    end
    checkOutput({tag, "LatW0"}, 32'(a0 - startC), 32'd0);
    checkOutput({tag, "LatW15"}, 32'(a15 - startC), 32'd15);
    checkOutput({tag, "RdataW0"}, r0, expRd);
    checkOutput({tag, "RdataW15"}, r15, expRd);
  endtask

  always @(negedge clk) begin : monitor
    expT e;
    if (rstN && ack) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedAck", 32'(ack), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("ackCycle", 32'(cyc), 32'(e.ackCycle));
        checkOutput("rdata", rdata, e.rdata);
        checkOutput("err", 32'(err), 32'(e.err));
        checkOutput("busyDuringAck", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] burstExp [4];
    expT e;
    int  base;

    rstN = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
    #12;
    checkOutput("rstAck", 32'(ack), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    checkOutput("rstRdata", rdata, 32'h0);
    @(negedge clk); rstN = 1'b1;
    @(negedge clk);

    // Store then load, and a load that wraps to index 0.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 32'h0, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 32'h200, 32'h0, 32'hA5A5A5A5, 1'b0);

    // req held high: alternating store/load, one transaction every 4 cycles.
    burstExp[0] = 32'hA5A5A5A5; burstExp[1] = 32'h1;
    burstExp[2] = 32'h1;        burstExp[3] = 32'h1;
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1;
    base = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      e.rdata = burstExp[k]; e.err = 1'b0; e.ackCycle = base + 4 * k + 2;
      expQ.push_back(e);
      @(posedge clk); #2;
      we = ~we;
      repeat (3) @(posedge clk);
    end
    #2 req = 1'b0;
    @(negedge clk);

    // Reset during WAIT aborts a store without writing.
    applyStimulus(1'b1, 32'h30, 32'h1234, 32'h1, 1'b0);
    applyStimulus(1'b0, 32'h30, 32'h0, 32'h1234, 1'b0);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h55;
    @(posedge clk); #2;
    req = 1'b0;
    @(posedge clk); #2;
    rstN = 1'b0;
    #1;
    checkOutput("abortAck", 32'(ack), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortErr", 32'(err), 32'd0);
    checkOutput("abortRdata", rdata, 32'h0);
    @(negedge clk); rstN = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 32'h30, 32'h0, 32'h1234, 1'b0);

    // Misaligned store to 0x31.
`ifdef MEM_ALIGN_CHK_EN
    applyStimulus(1'b1, 32'h31, 32'hFF, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h30, 32'h0, 32'h1234, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rdataHeld", rdata, 32'h1234);
`else
    applyStimulus(1'b1, 32'h31, 32'hFF, 32'h1234, 1'b0);
    applyStimulus(1'b0, 32'h30, 32'h0, 32'hFF, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rdataHeld", rdata, 32'hFF);
`endif
    checkOutput("pendingAcks", 32'(expQ.size()), 32'd0);

    // Zero and maximum wait-state variants.
    latencyRun(1'b1, 32'h10, 32'h77, 32'h0, "store");
    latencyRun(1'b0, 32'h10, 32'h0, 32'h77, "load");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
